// File: rtl/notif_pkg.sv
// notif_pkg: shared constants, types and helpers for the notification arbiter.
//   N_APPS / SEL_W : number of notification sources and width of their index
//   state_t        : arbiter FSM states
//   APP_*          : bit position of each app in the req/pend vectors
//   popcount8      : number of set bits in an 8-bit vector
//   sat_add8       : 8-bit add that sticks at 255 instead of wrapping
package notif_pkg;

   localparam int N_APPS = 8;
   localparam int SEL_W  = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] APP_WHATSAPP = 3'd0;
   localparam logic [SEL_W-1:0] APP_SMS      = 3'd1;
   localparam logic [SEL_W-1:0] APP_EMAIL    = 3'd2;
   localparam logic [SEL_W-1:0] APP_CALENDAR = 3'd3;
   localparam logic [SEL_W-1:0] APP_SOCIAL   = 3'd4;
   localparam logic [SEL_W-1:0] APP_NEWS     = 3'd5;
   localparam logic [SEL_W-1:0] APP_SYSTEM   = 3'd6;
   localparam logic [SEL_W-1:0] APP_CALLS    = 3'd7;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {5'b00000, b};
      if (sum[8]) begin
         return 8'hFF;
      end else begin
         return sum[7:0];
      end
   endfunction

endpackage

// File: rtl/notification_arbiter_if.sv
// notification_arbiter_if: bundle between event sources/consumer and the arbiter.
//   req      : per-app event pulses into the arbiter
//   ack      : consumer accepts the current offer
//   sel      : index of the offered app (drives the 8:1 notification mux)
//   valid    : sel holds a pending notification
//   pend     : pending-notification bits
//   drop_cnt : saturating count of lost notifications
// master = event source / consumer side, slave = arbiter side.
interface notification_arbiter_if;
   import notif_pkg::*;

   logic [N_APPS-1:0] req;
   logic              ack;
   logic [SEL_W-1:0]  sel;
   logic              valid;
   logic [N_APPS-1:0] pend;
   logic [7:0]        drop_cnt;

   modport master (output req, ack, input sel, valid, pend, drop_cnt);
   modport slave  (input req, ack, output sel, valid, pend, drop_cnt);
endinterface

// File: rtl/notif_rr_picker.sv
// notif_rr_picker: combinational choice of the next app to offer.
//   pend  : pending bits to choose from
//   last  : index that was served most recently
//   index : chosen app index (0 when nothing is pending)
//   found : at least one pending bit exists
// RR_MODE=1 scans upward starting just after last, wrapping at 8;
// RR_MODE=0 always takes the lowest pending index.
module notif_rr_picker
   import notif_pkg::*;
#(
   parameter int RR_MODE = 1
) (
   input  logic [N_APPS-1:0] pend,
   input  logic [SEL_W-1:0]  last,
   output logic [SEL_W-1:0]  index,
   output logic              found
);

   logic [SEL_W-1:0] cand_s;

   // First pending index in scan order; the first hit wins, later hits are ignored.
   always_comb begin
      index  = {SEL_W{1'b0}};
      found  = 1'b0;
      cand_s = {SEL_W{1'b0}};
      if (RR_MODE != 0) begin
         // k = 8 truncates to 0 in SEL_W bits, so the scan ends on last itself.
         for (int k = 1; k <= N_APPS; k++) begin
            cand_s = last + SEL_W'(k);
            if (!found && pend[cand_s]) begin
               found = 1'b1;
               index = cand_s;
            end else begin
               found = found;
            end
         end
      end else begin
         // Descending scan so the lowest set bit is the last one written.
         for (int i = N_APPS - 1; i >= 0; i--) begin
            if (pend[i]) begin
               found = 1'b1;
               index = SEL_W'(i);
            end else begin
               found = found;
            end
         end
      end
   end

endmodule

// File: rtl/notification_arbiter.sv
// notification_arbiter: collects per-app notification events into pending
// bits and offers them one at a time to a consumer.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : notification_arbiter_if.slave (req, ack in; sel, valid, pend, drop_cnt out)
// An event arriving while its app is already pending (and not being cleared
// by ack on that same edge) is lost and counted in drop_cnt.
module notification_arbiter
   import notif_pkg::*;
#(
   parameter int RR_MODE = 1
) (
   input logic                  clk,
   input logic                  rst,
   notification_arbiter_if.slave bus
);

   state_t            state_r, state_s;
   logic [SEL_W-1:0]  sel_r, sel_s;
   logic              valid_r, valid_s;
   logic [SEL_W-1:0]  last_r, last_s;
   logic [N_APPS-1:0] pend_r, pend_s;
   logic [7:0]        drop_cnt_r, drop_cnt_s;
   logic [N_APPS-1:0] clear_s;
   logic [N_APPS-1:0] drop_s;
   logic [SEL_W-1:0]  pick_idx_s;
   logic              pick_found_s;

   notif_rr_picker #(
      .RR_MODE(RR_MODE)
   ) u_picker (
      .pend  (pend_r),
      .last  (last_r),
      .index (pick_idx_s),
      .found (pick_found_s)
   );

   // Next-state, offer bookkeeping, pending-bit update and drop counting.
   always_comb begin
      state_s = state_r;
      sel_s   = sel_r;
      valid_s = valid_r;
      last_s  = last_r;
      clear_s = {N_APPS{1'b0}};
      case (state_r)
         IDLE: begin
            // ack is meaningless here; only pending work starts an offer.
            if (pick_found_s) begin
               sel_s   = pick_idx_s;
               valid_s = 1'b1;
               state_s = OFFER;
            end else begin
               valid_s = 1'b0;
            end
         end
         OFFER: begin
            if (bus.ack) begin
               clear_s = {{(N_APPS-1){1'b0}}, 1'b1} << sel_r;
               last_s  = sel_r;
               valid_s = 1'b0;
               state_s = IDLE;
            end else begin
               valid_s = 1'b1;
            end
         end
         default: begin
            valid_s = 1'b0;
            state_s = IDLE;
         end
      endcase
      // A req on the bit being acked re-arms it rather than counting as a drop.
      drop_s     = bus.req & pend_r & ~clear_s;
      pend_s     = (pend_r & ~clear_s) | bus.req;
      drop_cnt_s = sat_add8(drop_cnt_r, popcount8(drop_s));
   end

   // State and output registers; last resets to 7 so round-robin starts at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         sel_r      <= {SEL_W{1'b0}};
         valid_r    <= 1'b0;
         last_r     <= APP_CALLS;
         pend_r     <= {N_APPS{1'b0}};
         drop_cnt_r <= 8'd0;
      end else begin
         state_r    <= state_s;
         sel_r      <= sel_s;
         valid_r    <= valid_s;
         last_r     <= last_s;
         pend_r     <= pend_s;
         drop_cnt_r <= drop_cnt_s;
      end
   end

   assign bus.sel      = sel_r;
   assign bus.valid    = valid_r;
   assign bus.pend     = pend_r;
   assign bus.drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_notification_arbiter.sv
// Bench for notification_arbiter: one round-robin and one fixed-priority
// instance, each tracked by a behavioural model and compared every cycle.
module tb_notification_arbiter;
   import notif_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   notification_arbiter_if if_rr();
   notification_arbiter_if if_fp();

   notification_arbiter #(.RR_MODE(1)) u_rr (.clk(clk), .rst(rst), .bus(if_rr.slave));
   notification_arbiter #(.RR_MODE(0)) u_fp (.clk(clk), .rst(rst), .bus(if_fp.slave));

   logic [7:0] req_v [2];
   logic       ack_v [2];
   logic       valid_v [2];
   logic [2:0] sel_v [2];
   logic [7:0] pend_v [2];
   logic [7:0] drop_v [2];

   assign if_rr.req = req_v[0];
   assign if_rr.ack = ack_v[0];
   assign if_fp.req = req_v[1];
   assign if_fp.ack = ack_v[1];
   assign valid_v[0] = if_rr.valid;
   assign valid_v[1] = if_fp.valid;
   assign sel_v[0]   = if_rr.sel;
   assign sel_v[1]   = if_fp.sel;
   assign pend_v[0]  = if_rr.pend;
   assign pend_v[1]  = if_fp.pend;
   assign drop_v[0]  = if_rr.drop_cnt;
   assign drop_v[1]  = if_fp.drop_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int inst, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s inst=%0d actual=%0d required=%0d at %0t", name, inst, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [7:0] pend;
      bit         off;
      int         sel;
      int         last;
      int         drop;
   } mdl_t;

   mdl_t m [2];

   function automatic mdl_t mdl_reset();
      mdl_t n;
      n.pend = 8'h00;
      n.off  = 1'b0;
      n.sel  = 0;
      n.last = 7;
      n.drop = 0;
      return n;
   endfunction

   function automatic mdl_t mdl_next(mdl_t c, logic [7:0] r, logic a, bit rr);
      mdl_t n;
      int   clr;
      int   drops;
      bit   got;
      n     = c;
      clr   = -1;
      drops = 0;
      got   = 1'b0;
      if (c.off && a) begin
         clr    = c.sel;
         n.off  = 1'b0;
         n.last = c.sel;
      end else if (!c.off && c.pend != 8'h00) begin
         for (int k = 0; k < 8; k++) begin
            int j;
            j = rr ? (c.last + 1 + k) % 8 : k;
            if (!got && c.pend[j]) begin
               got   = 1'b1;
               n.sel = j;
            end
         end
         n.off = 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
         if (r[i] && c.pend[i] && i != clr) drops++;
         n.pend[i] = r[i] || (c.pend[i] && i != clr);
      end
      n.drop = (c.drop + drops > 255) ? 255 : c.drop + drops;
      return n;
   endfunction

   // Model advances on the same edges as the DUTs.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m[0] <= mdl_reset();
         m[1] <= mdl_reset();
      end else begin
         m[0] <= mdl_next(m[0], req_v[0], ack_v[0], 1'b1);
         m[1] <= mdl_next(m[1], req_v[1], ack_v[1], 1'b0);
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            check("cyc_valid", i, valid_v[i], m[i].off);
            check("cyc_sel",   i, sel_v[i],   m[i].sel);
            check("cyc_pend",  i, pend_v[i],  m[i].pend);
            check("cyc_drop",  i, drop_v[i],  m[i].drop);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [7:0] r0, input logic a0, input logic [7:0] r1, input logic a1);
      req_v[0] = r0;
      ack_v[0] = a0;
      req_v[1] = r1;
      ack_v[1] = a1;
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      req_v[0] = 8'h00; req_v[1] = 8'h00;
      ack_v[0] = 1'b0;  ack_v[1] = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
   endtask

   // Wait (bounded) for an offer on inst, record sel, ack it for one cycle.
   task automatic serve(input int inst, output int s);
      s = -1;
      req_v[0] = 8'h00; req_v[1] = 8'h00;
      ack_v[0] = 1'b0;  ack_v[1] = 1'b0;
      for (int t = 0; t < 10; t++) begin
         if (valid_v[inst]) begin
            s = sel_v[inst];
            ack_v[inst] = 1'b1;
            @(negedge clk);
            ack_v[inst] = 1'b0;
            return;
         end
         @(negedge clk);
      end
      check("serve_timeout", inst, 0, 1);
   endtask

   int s;
   int exp_rr [4] = '{0, 7, 0, 7};
   int exp_fp [4] = '{4, 5, 6, 7};

   initial begin
      req_v[0] = 8'h00; req_v[1] = 8'h00;
      ack_v[0] = 1'b0;  ack_v[1] = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("reset_valid", i, valid_v[i], 0);
         check("reset_sel",   i, sel_v[i],   0);
         check("reset_pend",  i, pend_v[i],  0);
         check("reset_drop",  i, drop_v[i],  0);
      end
      #2 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      // Single event: pend one cycle later, offer two cycles later, ack clears.
      do_reset();
      drive(8'h04, 1'b0, 8'h04, 1'b0);
      for (int i = 0; i < 2; i++) begin
         check("single_pend", i, pend_v[i], 8'h04);
         check("single_early_valid", i, valid_v[i], 0);
      end
      drive(8'h00, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 2; i++) begin
         check("single_valid", i, valid_v[i], 1);
         check("single_sel",   i, sel_v[i],   2);
      end
      drive(8'h00, 1'b1, 8'h00, 1'b1);
      for (int i = 0; i < 2; i++) begin
         check("single_ack_pend",  i, pend_v[i],  0);
         check("single_ack_valid", i, valid_v[i], 0);
      end
      drive(8'h00, 1'b0, 8'h00, 1'b0);

      // Round-robin order with wrap from last=7 back to 0.
      do_reset();
      drive(8'h81, 1'b0, 8'h81, 1'b0);
      for (int n = 0; n < 2; n++) begin
         serve(0, s);
         check("rr_order", 0, s, exp_rr[n]);
      end
      drive(8'h81, 1'b0, 8'h00, 1'b0);
      for (int n = 2; n < 4; n++) begin
         serve(0, s);
         check("rr_order", 0, s, exp_rr[n]);
      end

      // Fixed priority drains lowest first.
      do_reset();
      drive(8'hF0, 1'b0, 8'hF0, 1'b0);
      for (int n = 0; n < 4; n++) begin
         serve(1, s);
         check("fp_order", 1, s, exp_fp[n]);
      end

      // Drops on one app saturate at 255.
      do_reset();
      drive(8'h08, 1'b0, 8'h08, 1'b0);
      repeat (300) drive(8'h08, 1'b0, 8'h08, 1'b0);
      for (int i = 0; i < 2; i++) begin
         check("sat_single_drop", i, drop_v[i], 255);
         check("sat_single_pend", i, pend_v[i], 8'h08);
      end
      check("model_sat_drop", 0, m[0].drop, 255);

      // All eight apps dropping: +8 per edge, then saturation.
      do_reset();
      drive(8'hFF, 1'b0, 8'hFF, 1'b0);
      repeat (3) drive(8'hFF, 1'b0, 8'hFF, 1'b0);
      for (int i = 0; i < 2; i++) check("sat8_drop_24", i, drop_v[i], 24);
      repeat (40) drive(8'hFF, 1'b0, 8'hFF, 1'b0);
      for (int i = 0; i < 2; i++) check("sat8_drop_255", i, drop_v[i], 255);

      // Re-request on the ack edge keeps the bit and is not a drop.
      do_reset();
      drive(8'h20, 1'b0, 8'h20, 1'b0);
      drive(8'h00, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 2; i++) check("rereq_sel", i, sel_v[i], 5);
      drive(8'h20, 1'b1, 8'h20, 1'b1);
      for (int i = 0; i < 2; i++) begin
         check("rereq_pend",  i, pend_v[i],  8'h20);
         check("rereq_drop",  i, drop_v[i],  0);
         check("rereq_gap",   i, valid_v[i], 0);
      end
      drive(8'h00, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 2; i++) begin
         check("rereq_valid2", i, valid_v[i], 1);
         check("rereq_sel2",   i, sel_v[i],   5);
      end

      // Asynchronous reset while offering; ack on first edge after release ignored.
      do_reset();
      drive(8'h3C, 1'b0, 8'h3C, 1'b0);
      drive(8'h3C, 1'b0, 8'h3C, 1'b0);
      for (int i = 0; i < 2; i++) begin
         check("rstmid_pre_valid", i, valid_v[i], 1);
         check("rstmid_pre_drop",  i, drop_v[i],  4);
      end
      req_v[0] = 8'h00; req_v[1] = 8'h00;
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rstmid_valid", i, valid_v[i], 0);
         check("rstmid_pend",  i, pend_v[i],  0);
         check("rstmid_drop",  i, drop_v[i],  0);
      end
      ack_v[0] = 1'b1; ack_v[1] = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) check("rstmid_ack_ignored", i, valid_v[i], 0);
      drive(8'h00, 1'b0, 8'h00, 1'b0);

      // Randomized traffic with sparse requests and random acks.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            drive(8'($urandom & $urandom & $urandom), 1'($urandom_range(0, 1)),
                  8'($urandom & $urandom & $urandom), 1'($urandom_range(0, 1)));
         end
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
